multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Main control FSM and ALU decoder for the RV32I-subset multicycle processor; sequences PC, instruction register, register file, ALU and the unified instruction/data memory.
- Sits between the datapath and the memory port inside the top-level multicycle processor.
- Holds the core idle until the clock PLL reports lock.
- Provides a memory request/ready handshake, a memory watchdog and a retired-instruction counter.

Parameters:
- COUNT_W, 32, width of retired-instruction counter
- TIMEOUT, 255, max cycles waiting for mem_ready_pi before trapping (min 1)

Ports:
- clk_pi  in  1  system clock
- rst_pi  in  1  asynchronous reset, active-low
- locked_pi  in  1  PLL lock; core runs only while high
- op_pi  in  7  instr[6:0]
- funct3_pi  in  3  instr[14:12]
- funct7b5_pi  in  1  instr[30]
- zero_pi  in  1  ALU zero flag
- mem_ready_pi  in  1  memory completes current access this cycle
- mem_req_po  out  1  memory access request
- mem_write_po  out  1  store strobe (only with mem_ready_pi)
- ir_write_po  out  1  load IR/OldPC (only with mem_ready_pi)
- pc_write_po  out  1  PC update
- adr_src_po  out  1  0=PC, 1=ALUOut
- reg_write_po  out  1  register file write
- result_src_po  out  2  00 ALUOut, 01 Data, 10 ALUResult
- alu_src_a_po  out  2  00 PC, 01 OldPC, 10 RegA
- alu_src_b_po  out  2  00 RegB, 01 ImmExt, 10 const 4
- imm_src_po  out  2  00 I, 01 S, 10 B, 11 J
- alu_control_po  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- halt_po  out  1  trap flag
- instr_count_po  out  COUNT_W  retired instructions

Behaviour:
- Reset (rst_pi=0, async): state IDLE, watchdog 0, instr_count_po 0, halt_po 0; all outputs 0 while in IDLE.
- Outputs are Moore-decoded from state plus registered IR fields (op/funct inputs); pc_write_po in BEQ also uses zero_pi.
- States/transitions:
  - IDLE -> FETCH when locked_pi=1.
  - FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu add, result_src=10. Waits until mem_ready_pi=1; that cycle asserts ir_write and pc_write, -> DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, imm_src=10, add. Next by op_pi: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; other -> TRAP.
  - MEMADR: alu_src_a=10, alu_src_b=01, add, imm_src=00 (lw) / 01 (sw); lw -> MEMREAD, sw -> MEMWRITE.
  - MEMREAD: mem_req=1, adr_src=1; on ready -> MEMWB.
  - MEMWRITE: mem_req=1, adr_src=1; mem_write=1 only in the ready cycle; on ready -> FETCH (retire).
  - MEMWB: result_src=01, reg_write=1 -> FETCH (retire).
  - EXECR: alu_src_a=10, alu_src_b=00 -> ALUWB.
  - EXECI: alu_src_a=10, alu_src_b=01, imm_src=00 -> ALUWB.
  - ALUWB: result_src=00, reg_write=1 -> FETCH (retire).
  - BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero_pi -> FETCH (retire).
  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1; -> ALUWB (retire there).
  - TRAP: halt_po=1, all control strobes 0; left only by reset.
- ALU decode applies to EXECR/EXECI only, else fixed as above:
  - f3 000: sub if R-type and funct7b5=1, else add.
  - f3 010: slt. f3 110: or. f3 111: and.
  - other f3 -> TRAP (from DECODE).
- Retire: instr_count_po += 1 on every transition into FETCH from an execution state; wraps modulo 2^COUNT_W.
- Watchdog: counts consecutive cycles with mem_req=1 and mem_ready=0. Reaching TIMEOUT -> TRAP. Clears on ready or on leaving a memory state.
- locked_pi falls in any non-TRAP state: next state IDLE; the in-flight instruction is aborted and not counted; counter holds its value.

Test Plan:
- Reset with locked_pi=0 for 10 cycles -> all outputs 0; raise locked -> FETCH next cycle, mem_req_po=1, alu_src_b_po=10.
- add (op 0110011, f3 000, f7b5 0), mem_ready held high -> states FETCH, DECODE, EXECR, ALUWB; reg_write_po=1 in cycle 4; instr_count_po 0->1.
- lw with mem_ready_pi delayed 3 cycles in both FETCH and MEMREAD -> mem_req held; ir_write_po pulses once; retires after 5+6=11 cycles.
- beq with zero_pi=1, then with zero_pi=0 -> pc_write_po=1 in BEQ only in the first case; alu_control_po=001.
- Opcode 1111111 -> TRAP after DECODE, halt_po=1 until rst_pi low; TIMEOUT=4 with ready never -> TRAP 4 cycles into FETCH.
- locked_pi drops during MEMREAD -> IDLE next cycle, instr_count_po unchanged; rst_pi low mid-EXECR -> immediate IDLE, counter 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Main control FSM and ALU decoder for the RV32I-subset multicycle core.
// It adds a memory request/ready handshake, a memory watchdog and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int COUNT_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk_pi,
  input  logic               rst_pi,
  input  logic               locked_pi,
  input  logic [6:0]         op_pi,
  input  logic [2:0]         funct3_pi,
  input  logic               funct7b5_pi,
  input  logic               zero_pi,
  input  logic               mem_ready_pi,
  output logic               mem_req_po,
  output logic               mem_write_po,
  output logic               ir_write_po,
  output logic               pc_write_po,
  output logic               adr_src_po,
  output logic               reg_write_po,
  output logic [1:0]         result_src_po,
  output logic [1:0]         alu_src_a_po,
  output logic [1:0]         alu_src_b_po,
  output logic [1:0]         imm_src_po,
  output logic [2:0]         alu_control_po,
  output logic               halt_po,
  output logic [COUNT_W-1:0] instr_count_po
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_t;

  state_t          state, state_next;
  logic [WD_W-1:0] wd;
  logic            f3_legal;
  logic            retire;
  logic [2:0]      alu_dec;

  assign f3_legal = funct3_pi inside {3'b000, 3'b010, 3'b110, 3'b111};
  assign retire   = (state_next == S_FETCH) &&
                    (state inside {S_MEMWRITE, S_MEMWB, S_ALUWB, S_BEQ});

  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3_pi)
      3'b000:  alu_dec = (op_pi == OP_RTYPE && funct7b5_pi) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  // The watchdog only runs while a memory state stalls; any state change clears it.
  always_ff @(posedge clk_pi or negedge rst_pi) begin
    if (!rst_pi) begin
      state          <= S_IDLE;
      wd             <= '0;
      instr_count_po <= '0;
    end else begin
      state <= state_next;
      if (mem_req_po && !mem_ready_pi && (state_next == state))
        wd <= wd + 1'b1;
      else
        wd <= '0;
      if (retire)
        instr_count_po <= instr_count_po + COUNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (locked_pi) state_next = S_FETCH;
      S_FETCH: begin
        if (mem_ready_pi)       state_next = S_DECODE;
        else if (wd == WD_LAST) state_next = S_TRAP;
      end
      S_DECODE: begin
        case (op_pi)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = f3_legal ? S_EXECR : S_TRAP;
          OP_ITYPE:          state_next = f3_legal ? S_EXECI : S_TRAP;
          OP_BRANCH:         state_next = S_BEQ;
          OP_JAL:            state_next = S_JAL;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   state_next = op_pi[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (mem_ready_pi)       state_next = S_MEMWB;
        else if (wd == WD_LAST) state_next = S_TRAP;
      end
      S_MEMWRITE: begin
        if (mem_ready_pi)       state_next = S_FETCH;
        else if (wd == WD_LAST) state_next = S_TRAP;
      end
      S_MEMWB, S_ALUWB, S_BEQ:  state_next = S_FETCH;
      S_EXECR, S_EXECI, S_JAL:  state_next = S_ALUWB;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_IDLE;
    endcase
    // Losing PLL lock aborts whatever is in flight; only a trap survives it.
    if (!locked_pi && state != S_TRAP)
      state_next = S_IDLE;
  end

  always_comb begin
    mem_req_po     = 1'b0;
    mem_write_po   = 1'b0;
    ir_write_po    = 1'b0;
    pc_write_po    = 1'b0;
    adr_src_po     = 1'b0;
    reg_write_po   = 1'b0;
    result_src_po  = 2'b00;
    alu_src_a_po   = 2'b00;
    alu_src_b_po   = 2'b00;
    imm_src_po     = 2'b00;
    alu_control_po = ALU_ADD;
    halt_po        = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req_po    = 1'b1;
        alu_src_b_po  = 2'b10;
        result_src_po = 2'b10;
        ir_write_po   = mem_ready_pi;
        pc_write_po   = mem_ready_pi;
      end
      S_DECODE: begin
        alu_src_a_po = 2'b01;
        alu_src_b_po = 2'b01;
        imm_src_po   = 2'b10;
      end
      S_MEMADR: begin
        alu_src_a_po = 2'b10;
        alu_src_b_po = 2'b01;
        imm_src_po   = op_pi[5] ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        mem_req_po = 1'b1;
        adr_src_po = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_po   = 1'b1;
        adr_src_po   = 1'b1;
        mem_write_po = mem_ready_pi;
      end
      S_MEMWB: begin
        result_src_po = 2'b01;
        reg_write_po  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_po   = 2'b10;
        alu_control_po = alu_dec;
      end
      S_EXECI: begin
        alu_src_a_po   = 2'b10;
        alu_src_b_po   = 2'b01;
        alu_control_po = alu_dec;
      end
      S_ALUWB:  reg_write_po = 1'b1;
      S_BEQ: begin
        alu_src_a_po   = 2'b10;
        alu_control_po = ALU_SUB;
        pc_write_po    = zero_pi;
      end
      S_JAL: begin
        alu_src_a_po = 2'b01;
        alu_src_b_po = 2'b10;
        pc_write_po  = 1'b1;
      end
      S_TRAP:   halt_po = 1'b1;
      default: ;
    endcase
  end

endmodule
